program_counter_unit: RTL and testbench

- Parametrised next-generation program counter for the single-cycle/pipelined datapath; replaces the plain load-only PC register.
- Selects and registers the next fetch address: sequential increment, branch, jump, call/return, exception vector, stall hold.
- Contains a circular return-address stack (RAS) for call/return.
- PCResult drives instruction memory address; PCPlus feeds the link/writeback path.

---
 rtl/program_counter_unit.sv | 121 ++++++++++++
 tb/tb_program_counter_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/program_counter_unit.sv
// Program counter with next-PC selection and a circular return-address stack.
// PCResult is the registered fetch address; PCPlus is the combinational link value.
module program_counter_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      INCR         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Exception,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Ret,
  input  logic [WIDTH-1:0] Target,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             AlignErr,
  output logic             RasUnderflow
);

  localparam int unsigned      PW      = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INCR_W  = WIDTH'(INCR);
  localparam logic [PW:0]      DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             empty_q, full_q, align_q, unf_q;
  logic             align_d, unf_d;
  logic             ras_we;
  logic [PW-1:0]    ras_wa;
  logic [WIDTH-1:0] tgt_al;
  logic             tgt_mis;
  logic             ras_nonempty;

  assign PCPlus       = pc_q + INCR_W;
  assign PCResult     = pc_q;
  assign RasEmpty     = empty_q;
  assign RasFull      = full_q;
  assign AlignErr     = align_q;
  assign RasUnderflow = unf_q;

  assign tgt_al       = {Target[WIDTH-1:2], 2'b00};
  assign tgt_mis      = |Target[1:0];
  assign ras_nonempty = (cnt_q != '0);

  // Next-PC and RAS control selection in priority order.
  // A push always lands at top+1; when the stack is full that slot is the
  // oldest entry, so the circular overwrite needs no separate handling.
  always_comb begin
    pc_d    = PCPlus;
    top_d   = top_q;
    cnt_d   = cnt_q;
    align_d = 1'b0;
    unf_d   = 1'b0;
    ras_we  = 1'b0;
    ras_wa  = top_q;
    if (Exception) begin
      pc_d = EXC_VECTOR;
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (Ret && Call && ras_nonempty) begin
      pc_d    = tgt_al;
      align_d = tgt_mis;
      ras_we  = 1'b1;
      ras_wa  = top_q;
    end else if (Call) begin
      pc_d    = tgt_al;
      align_d = tgt_mis;
      ras_we  = 1'b1;
      ras_wa  = top_q + PW'(1);
      top_d   = top_q + PW'(1);
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + (PW+1)'(1);
    end else if (Ret) begin
      if (ras_nonempty) begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - (PW+1)'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (Jump || Branch) begin
      pc_d    = tgt_al;
      align_d = tgt_mis;
    end
  end

  // Register PC, stack pointers, status flags and event pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      align_q <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == DEPTH_C);
      align_q <= align_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are don't-care while count is zero.
  always_ff @(posedge Clk) begin
    if (!Reset && ras_we) ras_q[ras_wa] <= PCPlus;
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit: directed plan plus random controls
// compared against a queue-based reference model.
module tb_program_counter_unit;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Exception, Branch, Jump, Call, Ret;
  logic [31:0] Target;
  logic [31:0] PCResult, PCPlus;
  logic        RasEmpty, RasFull, AlignErr, RasUnderflow;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: return addresses as a queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  bit          m_align, m_unf;

  program_counter_unit #(
    .WIDTH(32), .INCR(4), .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Exception(Exception),
    .Branch(Branch), .Jump(Jump), .Call(Call), .Ret(Ret), .Target(Target),
    .PCResult(PCResult), .PCPlus(PCPlus), .RasEmpty(RasEmpty),
    .RasFull(RasFull), .AlignErr(AlignErr), .RasUnderflow(RasUnderflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(bit r, bit e, bit s, bit b, bit j, bit c, bit rt,
                                logic [31:0] t);
    logic [31:0] link;
    logic [31:0] al;
    link    = m_pc + 32'd4;
    al      = t & 32'hFFFF_FFFC;
    m_align = 1'b0;
    m_unf   = 1'b0;
    if (r) begin
      m_pc = 32'h0;
      m_stack.delete();
    end else if (e) begin
      m_pc = 32'h180;
    end else if (s) begin
      // hold
    end else if (c) begin
      if (rt && m_stack.size() != 0) m_stack[m_stack.size()-1] = link;
      else begin
        m_stack.push_back(link);
        if (m_stack.size() > 4) void'(m_stack.pop_front());
      end
      m_pc    = al;
      m_align = (t[1:0] != 2'b00);
    end else if (rt) begin
      if (m_stack.size() != 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = link;
        m_unf = 1'b1;
      end
    end else if (j || b) begin
      m_pc    = al;
      m_align = (t[1:0] != 2'b00);
    end else begin
      m_pc = link;
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit s, input bit b, input bit j,
                      input bit c, input bit rt, input logic [31:0] t);
    Reset = r; Exception = e; Stall = s; Branch = b; Jump = j;
    Call = c; Ret = rt; Target = t;
    @(posedge Clk);
    model(r, e, s, b, j, c, rt, t);
    #1;
    chk("pc",    PCResult,     m_pc);
    chk("pcplus", PCPlus,      m_pc + 32'd4);
    chk("empty", {31'd0, RasEmpty},     {31'd0, m_stack.size() == 0});
    chk("full",  {31'd0, RasFull},      {31'd0, m_stack.size() == 4});
    chk("align", {31'd0, AlignErr},     {31'd0, m_align});
    chk("unf",   {31'd0, RasUnderflow}, {31'd0, m_unf});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Exception = 1'b0; Branch = 1'b0;
    Jump = 1'b0; Call = 1'b0; Ret = 1'b0; Target = '0;
    m_pc = '0;

    // Reset for two cycles, then sequential fetch.
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_empty", {31'd0, RasEmpty}, 32'd1);
    idle(); chk("seq4", PCResult, 32'h4);
    idle(); chk("seq8", PCResult, 32'h8);
    idle(); chk("seqC", PCResult, 32'hC);
    idle(); chk("seq10", PCResult, 32'h10);

    // Misaligned jump target.
    step(0, 0, 0, 0, 1, 0, 0, 32'h0000_1003);
    chk("jmp_pc", PCResult, 32'h1000);
    chk("jmp_align", {31'd0, AlignErr}, 32'd1);
    idle();
    chk("jmp_next", PCResult, 32'h1004);
    chk("align_clr", {31'd0, AlignErr}, 32'd0);

    // Call then return.
    step(0, 0, 0, 0, 1, 0, 0, 32'h40);
    step(0, 0, 0, 0, 0, 1, 0, 32'h200); chk("call_pc", PCResult, 32'h200);
    idle(); idle(); chk("at208", PCResult, 32'h208);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0);
    chk("ret_pc", PCResult, 32'h44);
    chk("ret_empty", {31'd0, RasEmpty}, 32'd1);

    // Five nested calls overflow a 4-deep stack, then five returns.
    step(0, 0, 0, 0, 1, 0, 0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, 32'(i) * 32'h100);
      if (i == 4) chk("full4", {31'd0, RasFull}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("r1", PCResult, 32'h404);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("r2", PCResult, 32'h304);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("r3", PCResult, 32'h204);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0); chk("r4", PCResult, 32'h104);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0);
    chk("r5_pc", PCResult, 32'h108);
    chk("r5_unf", {31'd0, RasUnderflow}, 32'd1);
    idle();
    chk("unf_clr", {31'd0, RasUnderflow}, 32'd0);

    // Stall beats branch; exception beats stall.
    step(0, 0, 0, 0, 1, 0, 0, 32'h20);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0, 32'h800);
    chk("stall_pc", PCResult, 32'h20);
    step(0, 1, 1, 1, 0, 0, 0, 32'h800);
    chk("exc_pc", PCResult, 32'h180);

    // Reset mid-sequence with stacked entries, then wrap at top of address space.
    step(0, 0, 0, 0, 0, 1, 0, 32'h300);
    step(0, 0, 0, 0, 0, 1, 0, 32'h400);
    step(1, 0, 0, 0, 0, 1, 0, 32'h500);
    chk("rst2_pc", PCResult, 32'h0);
    chk("rst2_empty", {31'd0, RasEmpty}, 32'd1);
    chk("rst2_full", {31'd0, RasFull}, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
    idle();
    chk("wrap", PCResult, 32'h0);

    // Tail call on a non-empty stack, then on an empty one.
    step(0, 0, 0, 0, 0, 1, 0, 32'h600);
    step(0, 0, 0, 0, 0, 1, 1, 32'h702);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h900);

    // Random controls against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] t;
      t = $urandom();
      if ($urandom_range(0, 3) != 0) t = t & 32'h0000_0FFC;
      step($urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
